// File: rtl/nx_fifo_wm.sv
// rtl/nx_fifo_wm.sv - parametrised show-ahead FIFO with thresholds, watermark and error flags
//
// Ports:
//   clk, rst            clock (posedge), synchronous active-high reset
//   clear               synchronous flush of pointers, count and watermark
//   wen, wdata          write request and data
//   ren, rdata          read request (pops head) and head entry (0 when empty)
//   empty, full         occupancy is 0 / DEPTH
//   afull, aempty       occupancy >= afull_thresh / <= aempty_thresh
//   afull_thresh        almost-full level (quasi-static)
//   aempty_thresh       almost-empty level (quasi-static)
//   used_slots          current occupancy
//   free_slots          DEPTH - used_slots
//   high_wm, wm_clr     peak occupancy since rst/clear/wm_clr; reload request
//   overflow, underflow registered 1-cycle pulses for rejected write / read
//   err_sticky          {overflow_seen, underflow_seen}, cleared only by rst
module nx_fifo_wm #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 106,
  parameter int DATA_RESET = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             afull,
  output logic             aempty,
  input  logic [CW-1:0]    afull_thresh,
  input  logic [CW-1:0]    aempty_thresh,
  output logic [CW-1:0]    used_slots,
  output logic [CW-1:0]    free_slots,
  output logic [CW-1:0]    high_wm,
  input  logic             wm_clr,
  output logic             overflow,
  output logic             underflow,
  output logic [1:0]       err_sticky
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    high_wm_q, high_wm_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [1:0]       err_sticky_q, err_sticky_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic wr_acc;
  logic rd_acc;

  // Status flags all come straight off the registered count.
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign afull      = (count_q >= afull_thresh);
  assign aempty     = (count_q <= aempty_thresh);
  assign used_slots = count_q;
  assign free_slots = CW'(DEPTH) - count_q;
  assign high_wm    = high_wm_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign err_sticky = err_sticky_q;
  assign rdata      = empty ? '0 : mem_q[rptr_q];

  // A flush cycle swallows both requests, so no accept and no error pulse.
  assign wr_acc = wen && !full && !clear;
  assign rd_acc = ren && !empty && !clear;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    high_wm_d    = high_wm_q;
    overflow_d   = wen && full && !clear;
    underflow_d  = ren && empty && !clear;
    err_sticky_d = err_sticky_q | {overflow_d, underflow_d};

    // Explicit wrap keeps non-power-of-two depths inside 0..DEPTH-1.
    if (wr_acc) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    if (rd_acc) rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);

    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

    // Watermark tracks the post-edge count; a reload request overrides the max.
    if (wm_clr)                  high_wm_d = count_d;
    else if (count_d > high_wm_q) high_wm_d = count_d;

    if (clear) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      high_wm_d = '0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) mem_d[wptr_q] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      high_wm_q    <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      err_sticky_q <= 2'b00;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      high_wm_q    <= high_wm_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Storage reset is optional; without it the array simply holds through rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (DATA_RESET != 0) mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_nx_fifo_wm.sv
// tb/tb_nx_fifo_wm.sv - randomized and directed bench for nx_fifo_wm against a queue model
module tb_nx_fifo_wm;

  localparam int DEPTH = 5;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             wen = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             ren = 1'b0;
  logic [WIDTH-1:0] rdata;
  logic             empty, full, afull, aempty;
  logic [CW-1:0]    afull_thresh = CW'(3);
  logic [CW-1:0]    aempty_thresh = CW'(1);
  logic [CW-1:0]    used_slots, free_slots, high_wm;
  logic             wm_clr = 1'b0;
  logic             overflow, underflow;
  logic [1:0]       err_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] m_q [$];
  int               m_hwm = 0;
  bit               m_ovf = 0;
  bit               m_unf = 0;
  bit [1:0]         m_sticky = 0;

  nx_fifo_wm #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATA_RESET(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata), .empty(empty), .full(full), .afull(afull), .aempty(aempty),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .used_slots(used_slots), .free_slots(free_slots), .high_wm(high_wm),
    .wm_clr(wm_clr), .overflow(overflow), .underflow(underflow),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int sz;
    bit wa, ra;
    sz = m_q.size();
    if (rst) begin
      m_q.delete();
      m_hwm = 0; m_ovf = 0; m_unf = 0; m_sticky = 0;
    end else if (clear) begin
      m_q.delete();
      m_hwm = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_ovf = wen && (sz == DEPTH);
      m_unf = ren && (sz == 0);
      ra = ren && (sz != 0);
      wa = wen && (sz != DEPTH);
      if (ra) void'(m_q.pop_front());
      if (wa) m_q.push_back(wdata);
      if (wm_clr) m_hwm = m_q.size();
      else if (m_q.size() > m_hwm) m_hwm = m_q.size();
      m_sticky |= {m_ovf, m_unf};
    end
  endtask

  task automatic check_all();
    int sz;
    sz = m_q.size();
    check_eq("rdata", int'(rdata), (sz != 0) ? int'(m_q[0]) : 0);
    check_eq("empty", int'(empty), int'(sz == 0));
    check_eq("full", int'(full), int'(sz == DEPTH));
    check_eq("used_slots", int'(used_slots), sz);
    check_eq("free_slots", int'(free_slots), DEPTH - sz);
    check_eq("afull", int'(afull), int'(sz >= int'(afull_thresh)));
    check_eq("aempty", int'(aempty), int'(sz <= int'(aempty_thresh)));
    check_eq("high_wm", int'(high_wm), m_hwm);
    check_eq("overflow", int'(overflow), int'(m_ovf));
    check_eq("underflow", int'(underflow), int'(m_unf));
    check_eq("err_sticky", int'(err_sticky), int'(m_sticky));
  endtask

  // Called at a negedge: drive, clock, update model, check just after the edge.
  task automatic cycle(input logic r, input logic c, input logic w,
                       input logic [WIDTH-1:0] d, input logic rd, input logic wc);
    rst = r; clear = c; wen = w; wdata = d; ren = rd; wm_clr = wc;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0; clear = 1'b0; wen = 1'b0; ren = 1'b0; wm_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 8'h00, 0, 0);
    check_eq("rst_free", int'(free_slots), DEPTH);
    check_eq("rst_empty", int'(empty), 1);

    // Fill, then one rejected write.
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(8'h11 * (i + 1)), 0, 0);
    cycle(0, 0, 1, 8'h66, 0, 0);
    check_eq("t1_full", int'(full), 1);
    check_eq("t1_overflow", int'(overflow), 1);
    check_eq("t1_sticky", int'(err_sticky), 2);
    cycle(0, 0, 0, 8'h00, 0, 0);
    check_eq("t1_ovf_drop", int'(overflow), 0);

    // Drain past empty.
    for (int i = 0; i < 7; i++) begin
      if (i < 5) check_eq("t2_rdata", int'(rdata), 'h11 * (i + 1));
      cycle(0, 0, 0, 8'h00, 1, 0);
    end
    check_eq("t2_underflow", int'(underflow), 1);
    check_eq("t2_sticky", int'(err_sticky), 3);

    // Interleave across the wrap point.
    for (int k = 0; k < 13; k++) cycle(0, 0, 1, 8'(8'hA0 + k), (k >= 2), 0);
    while (!empty) cycle(0, 0, 0, 8'h00, 1, 0);

    // Simultaneous read/write at full and at empty.
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(8'h31 + i), 0, 0);
    cycle(0, 0, 1, 8'h99, 1, 0);
    check_eq("t4_ovf", int'(overflow), 1);
    check_eq("t4_cnt4", int'(used_slots), 4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1, 0);
    cycle(0, 0, 1, 8'h99, 1, 0);
    check_eq("t4_unf", int'(underflow), 1);
    check_eq("t4_cnt1", int'(used_slots), 1);
    check_eq("t4_rdata", int'(rdata), 'h99);

    // Thresholds and watermark reload.
    cycle(0, 1, 0, 8'h00, 0, 0);
    afull_thresh = CW'(3); aempty_thresh = CW'(1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'(8'h40 + i), 0, 0);
    check_eq("t5_afull4", int'(afull), 1);
    cycle(0, 0, 0, 8'h00, 1, 0);
    cycle(0, 0, 0, 8'h00, 1, 0);
    check_eq("t5_hwm4", int'(high_wm), 4);
    cycle(0, 0, 0, 8'h00, 0, 1);
    check_eq("t5_hwm2", int'(high_wm), 2);

    // clear with pending write, then rst mid-stream.
    cycle(0, 0, 1, 8'h77, 0, 0);
    cycle(0, 1, 1, 8'h78, 0, 0);
    check_eq("t6_cnt", int'(used_slots), 0);
    check_eq("t6_hwm", int'(high_wm), 0);
    check_eq("t6_sticky", int'(err_sticky), 3);
    cycle(0, 0, 1, 8'h79, 0, 0);
    cycle(0, 0, 1, 8'h7A, 0, 0);
    cycle(1, 0, 1, 8'h7B, 1, 1);
    check_eq("t6_rst_sticky", int'(err_sticky), 0);
    check_eq("t6_rst_rdata", int'(rdata), 0);

    // Threshold edge cases: 0 and beyond DEPTH.
    afull_thresh = CW'(0); aempty_thresh = CW'(7);
    cycle(0, 0, 0, 8'h00, 0, 0);
    afull_thresh = CW'(6); aempty_thresh = CW'(0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 8'(8'hC0 + i), 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        afull_thresh  = CW'($urandom_range(0, 7));
        aempty_thresh = CW'($urandom_range(0, 7));
      end
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 99) < 55), 8'($urandom),
            ($urandom_range(0, 99) < 50), ($urandom_range(0, 24) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
